// File: rtl/cc_mux_reg_bank.sv
// Registered one-hot register-file read mux with a valid/ready output stage,
// illegal-select detection and a saturating error counter.
module cc_mux_reg_bank #(
    parameter int NUM_REGS      = 38,
    parameter int DATAWIDTH_BUS = 32,
    parameter int ERR_HOLD      = 0,
    parameter int ERRCNT_WIDTH  = 8
) (
    input  logic                              CC_MUX_BANK_CLOCK_50,
    input  logic                              CC_MUX_BANK_RESET_InLow,
    input  logic [NUM_REGS*DATAWIDTH_BUS-1:0] CC_MUX_BANK_REGS_IN,
    input  logic [NUM_REGS-1:0]               CC_MUX_BANK_SEL_IN,
    input  logic                              CC_MUX_BANK_IN_VALID,
    output logic                              CC_MUX_BANK_IN_READY,
    output logic [DATAWIDTH_BUS-1:0]          CC_MUX_BANK_BUS_OUT,
    output logic                              CC_MUX_BANK_OUT_VALID,
    input  logic                              CC_MUX_BANK_OUT_READY,
    output logic                              CC_MUX_BANK_SEL_ERR,
    output logic [ERRCNT_WIDTH-1:0]           CC_MUX_BANK_ERR_COUNT,
    input  logic                              CC_MUX_BANK_ERR_CLR
);

    logic [DATAWIDTH_BUS-1:0] bus_q, bus_d;
    logic [DATAWIDTH_BUS-1:0] last_good_q, last_good_d;
    logic                     out_valid_q, out_valid_d;
    logic                     sel_err_q, sel_err_d;
    logic [ERRCNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

    logic [DATAWIDTH_BUS-1:0] word_sel;
    logic                     sel_legal;
    logic                     accept;

    // OR of masked words: a multi-hot select never reaches the bus because it is
    // flagged illegal, so no priority encoder is needed here.
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            word_sel = word_sel |
                (CC_MUX_BANK_REGS_IN[k*DATAWIDTH_BUS +: DATAWIDTH_BUS] & {DATAWIDTH_BUS{CC_MUX_BANK_SEL_IN[k]}});
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign sel_legal = (CC_MUX_BANK_SEL_IN != '0) &&
                       ((CC_MUX_BANK_SEL_IN & (CC_MUX_BANK_SEL_IN - NUM_REGS'(1))) == '0);

    assign CC_MUX_BANK_IN_READY = !out_valid_q || CC_MUX_BANK_OUT_READY;
    assign accept               = CC_MUX_BANK_IN_VALID && CC_MUX_BANK_IN_READY;

    always_comb begin
        bus_d       = bus_q;
        last_good_d = last_good_q;
        sel_err_d   = sel_err_q;
        err_cnt_d   = err_cnt_q;
        out_valid_d = accept || (out_valid_q && !CC_MUX_BANK_OUT_READY);

        if (CC_MUX_BANK_ERR_CLR) begin
            err_cnt_d = '0;
        end

        if (accept) begin
            if (sel_legal) begin
                bus_d       = word_sel;
                last_good_d = word_sel;
                sel_err_d   = 1'b0;
            end else begin
                bus_d     = (ERR_HOLD != 0) ? last_good_q : '0;
                sel_err_d = 1'b1;
                if (CC_MUX_BANK_ERR_CLR) begin
                    err_cnt_d = ERRCNT_WIDTH'(1);
                end else if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERRCNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge CC_MUX_BANK_CLOCK_50 or negedge CC_MUX_BANK_RESET_InLow) begin
        if (!CC_MUX_BANK_RESET_InLow) begin
            bus_q       <= '0;
            last_good_q <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            bus_q       <= bus_d;
            last_good_q <= last_good_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign CC_MUX_BANK_BUS_OUT   = bus_q;
    assign CC_MUX_BANK_OUT_VALID = out_valid_q;
    assign CC_MUX_BANK_SEL_ERR   = sel_err_q;
    assign CC_MUX_BANK_ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_cc_mux_reg_bank.sv
// Scoreboard bench for cc_mux_reg_bank: two instances (ERR_HOLD=0 / 8-bit counter,
// ERR_HOLD=1 / 4-bit counter) share stimulus; a negedge monitor pops expected results.
module tb_cc_mux_reg_bank;

    localparam int NR = 38;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [NR*DW-1:0]   regs;
    logic [NR-1:0]      sel;
    logic               in_valid;
    logic               out_ready;
    logic               err_clr;

    logic               in_ready_a, out_valid_a, sel_err_a;
    logic [DW-1:0]      bus_a;
    logic [7:0]         cnt_a;
    logic               in_ready_b, out_valid_b, sel_err_b;
    logic [DW-1:0]      bus_b;
    logic [3:0]         cnt_b;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    cc_mux_reg_bank #(.NUM_REGS(NR), .DATAWIDTH_BUS(DW), .ERR_HOLD(0), .ERRCNT_WIDTH(8)) dut_a (
        .CC_MUX_BANK_CLOCK_50   (clk),
        .CC_MUX_BANK_RESET_InLow(rst_n),
        .CC_MUX_BANK_REGS_IN    (regs),
        .CC_MUX_BANK_SEL_IN     (sel),
        .CC_MUX_BANK_IN_VALID   (in_valid),
        .CC_MUX_BANK_IN_READY   (in_ready_a),
        .CC_MUX_BANK_BUS_OUT    (bus_a),
        .CC_MUX_BANK_OUT_VALID  (out_valid_a),
        .CC_MUX_BANK_OUT_READY  (out_ready),
        .CC_MUX_BANK_SEL_ERR    (sel_err_a),
        .CC_MUX_BANK_ERR_COUNT  (cnt_a),
        .CC_MUX_BANK_ERR_CLR    (err_clr)
    );

    cc_mux_reg_bank #(.NUM_REGS(NR), .DATAWIDTH_BUS(DW), .ERR_HOLD(1), .ERRCNT_WIDTH(4)) dut_b (
        .CC_MUX_BANK_CLOCK_50   (clk),
        .CC_MUX_BANK_RESET_InLow(rst_n),
        .CC_MUX_BANK_REGS_IN    (regs),
        .CC_MUX_BANK_SEL_IN     (sel),
        .CC_MUX_BANK_IN_VALID   (in_valid),
        .CC_MUX_BANK_IN_READY   (in_ready_b),
        .CC_MUX_BANK_BUS_OUT    (bus_b),
        .CC_MUX_BANK_OUT_VALID  (out_valid_b),
        .CC_MUX_BANK_OUT_READY  (out_ready),
        .CC_MUX_BANK_SEL_ERR    (sel_err_b),
        .CC_MUX_BANK_ERR_COUNT  (cnt_b),
        .CC_MUX_BANK_ERR_CLR    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: a result presented with OUT_READY high is consumed at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid_a && out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_out", bus_a, 32'hxxxxxxxx);
            end else begin
                e = qa.pop_front();
                chk("a_bus", bus_a, e.d);
                chk("a_sel_err", {31'd0, sel_err_a}, {31'd0, e.e});
            end
        end
        if (rst_n && out_valid_b && out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_out", bus_b, 32'hxxxxxxxx);
            end else begin
                e = qb.pop_front();
                chk("b_bus", bus_b, e.d);
                chk("b_sel_err", {31'd0, sel_err_b}, {31'd0, e.e});
            end
        end
    end

    // Called just after a rising edge; the selection is accepted at the next edge.
    task automatic accept(input logic [NR-1:0] s,
                          input logic [DW-1:0] da, input logic ea,
                          input logic [DW-1:0] db, input logic eb);
        exp_t x;
        sel      = s;
        in_valid = 1'b1;
        x.d = da; x.e = ea; qa.push_back(x);
        x.d = db; x.e = eb; qb.push_back(x);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; regs = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        #2;
        chk("rst_bus", bus_a, 0);
        chk("rst_valid", {31'd0, out_valid_a}, 0);
        chk("rst_sel_err", {31'd0, sel_err_a}, 0);
        chk("rst_cnt", {24'd0, cnt_a}, 0);
        chk("rst_in_ready", {31'd0, in_ready_a}, 1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Sweep every word with back-to-back accepts.
        for (int k = 0; k < NR; k++) regs[k*DW +: DW] = 32'hA500_0000 + 32'(k);
        for (int k = 0; k < NR; k++) begin
            accept(NR'(1) << k, 32'hA500_0000 + 32'(k), 1'b0, 32'hA500_0000 + 32'(k), 1'b0);
            chk("sweep_valid", {31'd0, out_valid_a}, 1);
        end
        @(posedge clk); #1;

        // Illegal selections.
        for (int k = 0; k < NR; k++) regs[k*DW +: DW] = 32'(k) * 32'h11;
        accept(NR'(1) << 5, 32'h55, 1'b0, 32'h55, 1'b0);
        accept('0, 32'h0, 1'b1, 32'h55, 1'b1);
        accept((NR'(1) << 2) | (NR'(1) << 9), 32'h0, 1'b1, 32'h55, 1'b1);
        chk("illegal_cnt_a", {24'd0, cnt_a}, 2);
        chk("illegal_cnt_b", {28'd0, cnt_b}, 2);
        @(posedge clk); #1;

        // Backpressure: hold 0x33 for 4 cycles while inputs churn.
        sel = NR'(1) << 3; in_valid = 1'b1;
        begin exp_t x; x.d = 32'h33; x.e = 1'b0; qa.push_back(x); qb.push_back(x); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = NR'(1) << (7 + i);
            regs[3*DW +: DW] = 32'hDEAD_0000 + 32'(i);
            @(posedge clk); #1;
            chk("stall_bus", bus_a, 32'h33);
            chk("stall_in_ready", {31'd0, in_ready_a}, 0);
        end
        out_ready = 1'b1;
        sel = NR'(1) << 4;
        begin exp_t x; x.d = 32'h44; x.e = 1'b0; qa.push_back(x); qb.push_back(x); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("nobubble_valid", {31'd0, out_valid_a}, 1);
        chk("nobubble_bus", bus_a, 32'h44);
        @(posedge clk); #1;

        // Saturation and clear.
        for (int i = 0; i < 20; i++)
            accept((i % 2 == 0) ? NR'(0) : NR'(7), 32'h0, 1'b1, 32'h44, 1'b1);
        chk("sat_cnt_a", {24'd0, cnt_a}, 22);
        chk("sat_cnt_b", {28'd0, cnt_b}, 15);
        err_clr = 1'b1;
        accept('0, 32'h0, 1'b1, 32'h44, 1'b1);
        err_clr = 1'b0;
        chk("clr_ill_cnt_a", {24'd0, cnt_a}, 1);
        chk("clr_ill_cnt_b", {28'd0, cnt_b}, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("clr_cnt_a", {24'd0, cnt_a}, 0);
        chk("clr_cnt_b", {28'd0, cnt_b}, 0);

        // Async reset mid-stall.
        accept('0, 32'h0, 1'b1, 32'h44, 1'b1);
        accept(NR'(1) << 6, 32'h66, 1'b0, 32'h66, 1'b0);
        out_ready = 1'b0;
        chk("prerst_cnt_a", {24'd0, cnt_a}, 1);
        chk("prerst_valid", {31'd0, out_valid_a}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid_a}, 0);
        chk("arst_bus", bus_a, 0);
        chk("arst_cnt_a", {24'd0, cnt_a}, 0);
        chk("arst_cnt_b", {28'd0, cnt_b}, 0);
        chk("arst_bus_b", bus_b, 0);
        qa.delete();
        qb.delete();
        #3 rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", {31'd0, in_ready_a}, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("postrst_valid", {31'd0, out_valid_a}, 0);
        accept('0, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("postrst_cnt_a", {24'd0, cnt_a}, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
